// File: rtl/dma_data_fifo.sv
// ---------------------------------------------------------------------------
// dma_data_fifo
// Synchronous FIFO that buffers one DMA burst between the read side of the
// engine (producer) and the write side (consumer).
//
// Ports:
//   clk, rst_n       single rising-edge clock, asynchronous active-low reset
//   fifo_wen/wdata   push request and data
//   fifo_rden        pop request; fifo_rdata is valid the cycle after
//   fifo_rdata       registered pop data, holds when no pop is accepted
//   fifo_is_full     occupancy == DEPTH
//   fifo_is_empty    occupancy == 0
//   fifo_count       occupancy, 0..DEPTH
//   fifo_burst_room  at least BURST_LEN free entries
//   fifo_clear       synchronous flush (pointers, count, rdata)
//   err_clr          clears the sticky error flags
//   err_overflow     sticky: push attempted while full
//   err_underflow    sticky: pop attempted while empty
// ---------------------------------------------------------------------------
module dma_data_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned BURST_LEN  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fifo_wen,
  input  logic [DATA_WIDTH-1:0]     fifo_wdata,
  input  logic                      fifo_rden,
  output logic [DATA_WIDTH-1:0]     fifo_rdata,
  output logic                      fifo_is_full,
  output logic                      fifo_is_empty,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      fifo_burst_room,
  input  logic                      fifo_clear,
  input  logic                      err_clr,
  output logic                      err_overflow,
  output logic                      err_underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] BURST_C = (AW+1)'(BURST_LEN);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic                  full_s, empty_s, push_s, pop_s;
  logic                  ovf_set_s, udf_set_s;
  logic [AW:0]           room_s;

  // Flags come from the registered pointers; the extra MSB distinguishes
  // full from empty when the low bits match.
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Acceptance uses the flags at the edge, so a same-cycle pop never frees
  // room for a push into a full FIFO (and vice versa for empty).
  assign push_s    = fifo_wen  && !full_s  && !fifo_clear;
  assign pop_s     = fifo_rden && !empty_s && !fifo_clear;
  assign ovf_set_s = fifo_wen  &&  full_s  && !fifo_clear;
  assign udf_set_s = fifo_rden &&  empty_s && !fifo_clear;

  // count never exceeds DEPTH, so the subtraction cannot go negative.
  assign room_s = DEPTH_C - count_q;

  assign fifo_rdata      = rdata_q;
  assign fifo_is_full    = full_s;
  assign fifo_is_empty   = empty_s;
  assign fifo_count      = count_q;
  assign fifo_burst_room = (room_s >= BURST_C);
  assign err_overflow    = ovf_q;
  assign err_underflow   = udf_q;

  // Next-state computation for pointers, occupancy, read data and error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (fifo_clear) begin
      wr_ptr_d = {(AW+1){1'b0}};
      rd_ptr_d = {(AW+1){1'b0}};
      count_d  = {(AW+1){1'b0}};
      rdata_d  = {DATA_WIDTH{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + ONE_C;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + ONE_C;
        rdata_d  = mem_q[rd_ptr_q[AW-1:0]];
      end else begin
        rd_ptr_d = rd_ptr_q;
        rdata_d  = rdata_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end

    // A new error condition takes priority over err_clr in the same cycle.
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (err_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (udf_set_s) begin
      udf_d = 1'b1;
    end else if (err_clr) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  // Control/status registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
      count_q  <= {(AW+1){1'b0}};
      rdata_q  <= {DATA_WIDTH{1'b0}};
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array; deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= fifo_wdata;
    end
  end

endmodule

// File: tb/tb_dma_data_fifo.sv
// ---------------------------------------------------------------------------
// tb_dma_data_fifo
// Directed bench for dma_data_fifo. A queue-based reference model tracks the
// expected contents, read data and error flags; a compare process checks every
// status output against it on each falling edge, and directed steps add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_dma_data_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_wen;
  logic [31:0] fifo_wdata;
  logic        fifo_rden;
  logic [31:0] fifo_rdata;
  logic        fifo_is_full;
  logic        fifo_is_empty;
  logic [4:0]  fifo_count;
  logic        fifo_burst_room;
  logic        fifo_clear;
  logic        err_clr;
  logic        err_overflow;
  logic        err_underflow;

  int n_checks = 0;
  int n_err    = 0;

  dma_data_fifo #(.DATA_WIDTH(32), .DEPTH(16), .BURST_LEN(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fifo_wen        (fifo_wen),
    .fifo_wdata      (fifo_wdata),
    .fifo_rden       (fifo_rden),
    .fifo_rdata      (fifo_rdata),
    .fifo_is_full    (fifo_is_full),
    .fifo_is_empty   (fifo_is_empty),
    .fifo_count      (fifo_count),
    .fifo_burst_room (fifo_burst_room),
    .fifo_clear      (fifo_clear),
    .err_clr         (err_clr),
    .err_overflow    (err_overflow),
    .err_underflow   (err_underflow)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, plus last popped word and flags.
  logic [31:0] m_q[$];
  logic [31:0] m_rdata = 32'h0;
  logic        m_ovf   = 1'b0;
  logic        m_udf   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_rdata = 32'h0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      automatic bit was_full  = (m_q.size() == 16);
      automatic bit was_empty = (m_q.size() == 0);
      automatic bit ovf_hit   = fifo_wen  && was_full  && !fifo_clear;
      automatic bit udf_hit   = fifo_rden && was_empty && !fifo_clear;
      if (fifo_clear) begin
        m_q.delete();
        m_rdata = 32'h0;
      end else begin
        if (fifo_rden && !was_empty) m_rdata = m_q.pop_front();
        if (fifo_wen && !was_full) m_q.push_back(fifo_wdata);
      end
      if (ovf_hit) m_ovf = 1'b1;
      else if (err_clr) m_ovf = 1'b0;
      if (udf_hit) m_udf = 1'b1;
      else if (err_clr) m_udf = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("cmp_count", 32'(fifo_count), 32'(m_q.size()));
      chk("cmp_empty", 32'(fifo_is_empty), 32'(m_q.size() == 0));
      chk("cmp_full",  32'(fifo_is_full),  32'(m_q.size() == 16));
      chk("cmp_room",  32'(fifo_burst_room), 32'((16 - m_q.size()) >= 8));
      chk("cmp_rdata", fifo_rdata, m_rdata);
      chk("cmp_ovf",   32'(err_overflow),  32'(m_ovf));
      chk("cmp_udf",   32'(err_underflow), 32'(m_udf));
    end
  end

  // Drive one cycle of inputs (called at a falling edge) and wait until the
  // next falling edge, when the result of that cycle is visible.
  task automatic step(input logic w, input logic [31:0] d, input logic r,
                      input logic c, input logic e);
    fifo_wen   = w;
    fifo_wdata = d;
    fifo_rden  = r;
    fifo_clear = c;
    err_clr    = e;
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    fifo_wen   = 1'b0;
    fifo_wdata = 32'h0;
    fifo_rden  = 1'b0;
    fifo_clear = 1'b0;
    err_clr    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: reset state
    chk("t1_empty", 32'(fifo_is_empty), 32'd1);
    chk("t1_full",  32'(fifo_is_full), 32'd0);
    chk("t1_count", 32'(fifo_count), 32'd0);
    chk("t1_room",  32'(fifo_burst_room), 32'd1);
    chk("t1_rdata", fifo_rdata, 32'h0);
    chk("t1_ovf",   32'(err_overflow), 32'd0);
    chk("t1_udf",   32'(err_underflow), 32'd0);

    // 2: one burst in, one burst out
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0, 1'b0);
      chk("t2_room_push", 32'(fifo_burst_room), 32'd1);
    end
    chk("t2_count8", 32'(fifo_count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("t2_rdata", fifo_rdata, 32'h1000 + 32'(i));
      chk("t2_room_pop", 32'(fifo_burst_room), 32'd1);
    end
    chk("t2_count0", 32'(fifo_count), 32'd0);

    // 3: fill to full, then push+pop while full
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 32'h2000 + 32'(i), 1'b0, 1'b0, 1'b0);
      chk("t3_count", 32'(fifo_count), 32'(i + 1));
      chk("t3_room", 32'(fifo_burst_room), ((i + 1) <= 8) ? 32'd1 : 32'd0);
    end
    chk("t3_full", 32'(fifo_is_full), 32'd1);
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    chk("t3_ovf",   32'(err_overflow), 32'd1);
    chk("t3_count15", 32'(fifo_count), 32'd15);
    chk("t3_rdata", fifo_rdata, 32'h2000);
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("t3_drain", fifo_rdata, 32'h2000 + 32'(i));
    end
    chk("t3_empty", 32'(fifo_is_empty), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("t3_ovf_clr", 32'(err_overflow), 32'd0);

    // 4: push+pop on empty
    step(1'b1, 32'h0000_00A5, 1'b1, 1'b0, 1'b0);
    chk("t4_udf",   32'(err_underflow), 32'd1);
    chk("t4_count", 32'(fifo_count), 32'd1);
    chk("t4_rdata_hold", fifo_rdata, 32'h200F);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("t4_rdata", fifo_rdata, 32'h0000_00A5);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("t4_udf_clr", 32'(err_underflow), 32'd0);

    // 5: pointer wrap, three rounds of 12
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++)
        step(1'b1, 32'h3000 + 32'(r * 16 + i), 1'b0, 1'b0, 1'b0);
      chk("t5_count12", 32'(fifo_count), 32'd12);
      for (int i = 0; i < 12; i++) begin
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("t5_rdata", fifo_rdata, 32'h3000 + 32'(r * 16 + i));
      end
    end

    // 6: simultaneous push/pop, clear, and err_clr vs overflow
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h4000 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h4005, 1'b1, 1'b0, 1'b0);
    chk("t6_both_count", 32'(fifo_count), 32'd5);
    chk("t6_both_rdata", fifo_rdata, 32'h4000);
    step(1'b1, 32'h4BAD, 1'b1, 1'b1, 1'b0);
    chk("t6_clr_count", 32'(fifo_count), 32'd0);
    chk("t6_clr_empty", 32'(fifo_is_empty), 32'd1);
    chk("t6_clr_rdata", fifo_rdata, 32'h0);
    chk("t6_clr_ovf", 32'(err_overflow), 32'd0);
    chk("t6_clr_udf", 32'(err_underflow), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("t6_clr_no_udf", 32'(err_underflow), 32'd0);
    for (int i = 0; i < 16; i++)
      step(1'b1, 32'h5000 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h5BAD, 1'b0, 1'b0, 1'b1);
    chk("t6_ovf_wins", 32'(err_overflow), 32'd1);
    chk("t6_full_count", 32'(fifo_count), 32'd16);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("t6_ovf_clr", 32'(err_overflow), 32'd0);

    // 7: asynchronous reset while full discards everything
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_count", 32'(fifo_count), 32'd0);
    chk("t7_empty", 32'(fifo_is_empty), 32'd1);
    chk("t7_full",  32'(fifo_is_full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h6000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("t7_rdata", fifo_rdata, 32'h6000);
    chk("t7_count_end", 32'(fifo_count), 32'd0);

    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
